// File: rtl/fu_branch_queue.sv
// In-order branch functional-unit queue: entries wait for late operands via tag wakeup, the head
// resolves the branch and a registered output slot holds the result. FU_BRANCH_PREDICT_EN adds misprediction reporting.
module fu_branch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_kind,
    input  logic [2:0]              in_funct3,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [XLEN-1:0]         in_rs1,
    input  logic [XLEN-1:0]         in_rs2,
    input  logic                    in_ops_valid,
    input  logic [TAG_W-1:0]        in_tag,
`ifdef FU_BRANCH_PREDICT_EN
    input  logic                    in_pred_taken,
    input  logic [XLEN-1:0]         in_pred_target,
`endif
    input  logic                    wake_valid,
    input  logic [TAG_W-1:0]        wake_tag,
    input  logic [XLEN-1:0]         wake_rs1,
    input  logic [XLEN-1:0]         wake_rs2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_take,
    output logic [XLEN-1:0]         out_target,
    output logic [XLEN-1:0]         out_link,
`ifdef FU_BRANCH_PREDICT_EN
    output logic                    out_mispredict,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             valid;
        logic             ops_valid;
        logic [1:0]       kind;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [TAG_W-1:0] tag;
`ifdef FU_BRANCH_PREDICT_EN
        logic             pred_taken;
        logic [XLEN-1:0]  pred_target;
`endif
    } entry_t;

    entry_t [DEPTH-1:0] entries;
    entry_t             head_entry;

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             push, pop;
    logic             push_wake;
    logic             push_ops_valid;
    logic [XLEN-1:0]  push_rs1, push_rs2;

    logic             out_valid_reg;
    logic             out_take_reg;
    logic [XLEN-1:0]  out_target_reg, out_link_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic             res_take, res_cond;
    logic [XLEN-1:0]  res_target, res_link, jalr_sum;

    assign in_ready   = (count_reg < CNT_W'(DEPTH));
    assign count      = count_reg;
    assign head_entry = entries[head_reg];

    // Squash wins over everything, so it gates both push and pop.
    assign push = !squash && in_valid && in_ready;
    assign pop  = !squash && (count_reg != '0) && head_entry.valid && head_entry.ops_valid
                  && (!out_valid_reg || out_ready);

    // A matching same-cycle broadcast supplies the operands of the incoming entry.
    assign push_wake      = wake_valid && (in_tag == wake_tag);
    assign push_ops_valid = in_ops_valid || push_wake;
    assign push_rs1       = push_wake ? wake_rs1 : in_rs1;
    assign push_rs2       = push_wake ? wake_rs2 : in_rs2;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        entry_t entry_reg;
        logic   wake_hit;

        assign wake_hit = wake_valid && entry_reg.valid && !entry_reg.ops_valid
                          && (entry_reg.tag == wake_tag);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                entry_reg <= '0;
            end else if (squash) begin
                entry_reg.valid <= 1'b0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                entry_reg.valid     <= 1'b1;
                entry_reg.ops_valid <= push_ops_valid;
                entry_reg.kind      <= in_kind;
                entry_reg.funct3    <= in_funct3;
                entry_reg.pc        <= in_pc;
                entry_reg.imm       <= in_imm;
                entry_reg.rs1       <= push_rs1;
                entry_reg.rs2       <= push_rs2;
                entry_reg.tag       <= in_tag;
`ifdef FU_BRANCH_PREDICT_EN
                entry_reg.pred_taken  <= in_pred_taken;
                entry_reg.pred_target <= in_pred_target;
`endif
            end else begin
                if (pop && (head_reg == PTR_W'(gi)))
                    entry_reg.valid <= 1'b0;
                if (wake_hit) begin
                    entry_reg.ops_valid <= 1'b1;
                    entry_reg.rs1       <= wake_rs1;
                    entry_reg.rs2       <= wake_rs2;
                end
            end
        end

        assign entries[gi] = entry_reg;
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (squash) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            if (push)
                tail_reg <= tail_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Branch resolution of the head entry.
    always_comb begin
        res_cond = 1'b0;
        case (head_entry.funct3)
            3'b000:  res_cond = (head_entry.rs1 == head_entry.rs2);
            3'b001:  res_cond = (head_entry.rs1 != head_entry.rs2);
            3'b100:  res_cond = ($signed(head_entry.rs1) <  $signed(head_entry.rs2));
            3'b101:  res_cond = ($signed(head_entry.rs1) >= $signed(head_entry.rs2));
            3'b110:  res_cond = (head_entry.rs1 <  head_entry.rs2);
            3'b111:  res_cond = (head_entry.rs1 >= head_entry.rs2);
            default: res_cond = 1'b0;
        endcase
    end

    assign jalr_sum = head_entry.rs1 + head_entry.imm;
    assign res_link = head_entry.pc + XLEN'(4);

    always_comb begin
        res_take   = res_cond;
        res_target = head_entry.pc + head_entry.imm;
        case (head_entry.kind)
            2'b01: res_take = 1'b1;
            2'b10: begin
                res_take   = 1'b1;
                res_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: res_take = res_cond;
        endcase
    end

`ifdef FU_BRANCH_PREDICT_EN
    logic out_mispredict_reg;
    logic res_mispredict;

    assign res_mispredict = (res_take != head_entry.pred_taken)
                            || (res_take && (res_target != head_entry.pred_target));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            out_mispredict_reg <= 1'b0;
        else if (!squash && pop)
            out_mispredict_reg <= res_mispredict;
    end

    assign out_mispredict = out_mispredict_reg;
`endif

    // Output slot: payload only changes on issue, which requires the slot to be free or draining.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_take_reg   <= 1'b0;
            out_target_reg <= '0;
            out_link_reg   <= '0;
            out_tag_reg    <= '0;
        end else if (squash) begin
            out_valid_reg <= 1'b0;
        end else if (pop) begin
            out_valid_reg  <= 1'b1;
            out_take_reg   <= res_take;
            out_target_reg <= res_target;
            out_link_reg   <= res_link;
            out_tag_reg    <= head_entry.tag;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_take   = out_take_reg;
    assign out_target = out_target_reg;
    assign out_link   = out_link_reg;
    assign out_tag    = out_tag_reg;

endmodule

// File: tb/tb_fu_branch_queue.sv
// Scoreboard bench for fu_branch_queue: stimulus queues hand-computed results, a negedge monitor
// compares every presented output against the queue head and retires it on handshake.
module tb_fu_branch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        squash = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
    logic        in_ops_valid = 1'b0;
    logic [5:0]  in_tag = '0;
    logic        wake_valid = 1'b0;
    logic [5:0]  wake_tag = '0;
    logic [31:0] wake_rs1 = '0, wake_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_tag;
    logic        out_take;
    logic [31:0] out_target, out_link;
    logic [2:0]  count;
`ifdef FU_BRANCH_PREDICT_EN
    logic        in_pred_taken = 1'b0;
    logic [31:0] in_pred_target = '0;
    logic        out_mispredict;
`endif

    typedef struct {
        logic        take;
        logic [31:0] target;
        logic [31:0] link;
        logic [5:0]  tag;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   use_mis_g = 1'b0;
    logic e_mis_g = 1'b0;

    fu_branch_queue #(.XLEN(32), .DEPTH(4), .TAG_W(6)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ops_valid(in_ops_valid), .in_tag(in_tag),
`ifdef FU_BRANCH_PREDICT_EN
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
`endif
        .wake_valid(wake_valid), .wake_tag(wake_tag), .wake_rs1(wake_rs1), .wake_rs2(wake_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_take(out_take), .out_target(out_target), .out_link(out_link),
`ifdef FU_BRANCH_PREDICT_EN
        .out_mispredict(out_mispredict),
`endif
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic opsv, input logic [5:0] tag, input bit exp_on,
                        input logic e_take, input logic [31:0] e_target, input logic [31:0] e_link);
        exp_t e;
        chk("push_in_ready", in_ready, 1);
        in_kind = kind; in_funct3 = f3; in_pc = pc; in_imm = imm;
        in_rs1 = rs1; in_rs2 = rs2; in_ops_valid = opsv; in_tag = tag;
        if (exp_on) begin
            e.take = e_take; e.target = e_target; e.link = e_link; e.tag = tag;
            e.mis = use_mis_g ? e_mis_g : e_take;
            exp_q.push_back(e);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wake(input logic [5:0] tag, input logic [31:0] r1, input logic [31:0] r2);
        wake_valid = 1'b1; wake_tag = tag; wake_rs1 = r1; wake_rs2 = r2;
        tick();
        wake_valid = 1'b0;
    endtask

    // Monitor: checks the presented result every cycle (covers stall stability), retires on handshake.
    always @(negedge clock) begin
        if (!reset && !squash && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_tag", {58'd0, out_tag}, 64'hFFFF);
            end else begin
                chk("out_tag",    out_tag,    exp_q[0].tag);
                chk("out_take",   out_take,   exp_q[0].take);
                chk("out_target", out_target, exp_q[0].target);
                chk("out_link",   out_link,   exp_q[0].link);
`ifdef FU_BRANCH_PREDICT_EN
                chk("out_mispredict", out_mispredict, exp_q[0].mis);
`endif
                if (out_ready) begin
                    $display("txn tag=%0d take=%0d target=0x%08h link=0x%08h",
                             out_tag, out_take, out_target, out_link);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled while reset is held.
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_take", out_take, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_out_link", out_link, 0);
        chk("rst_out_tag", out_tag, 0);
        #1 reset = 1'b0;
        tick();

        // BEQ taken, one-cycle latency.
        out_ready = 1'b1;
        push(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1, 6'd1, 1, 1, 32'h120, 32'h104);
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_one_cycle", out_valid, 1);
        tick();

        // Signed vs unsigned compare, in order.
        push(2'b00, 3'b100, 32'h200, 32'h10, 32'hFFFFFFFF, 32'd1, 1, 6'd2, 1, 1, 32'h210, 32'h204);
        push(2'b00, 3'b110, 32'h300, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1, 1, 6'd3, 1, 0, 32'h2F8, 32'h304);
        // Remaining conditions, illegal funct3/kind, JAL wrap.
        push(2'b00, 3'b001, 32'h700, 32'h10, 32'd3, 32'd4, 1, 6'd5, 1, 1, 32'h710, 32'h704);
        push(2'b00, 3'b101, 32'h710, 32'h20, 32'h80000000, 32'd0, 1, 6'd6, 1, 0, 32'h730, 32'h714);
        push(2'b00, 3'b111, 32'h720, 32'h20, 32'h80000000, 32'd0, 1, 6'd7, 1, 1, 32'h740, 32'h724);
        push(2'b00, 3'b010, 32'h730, 32'h8, 32'd5, 32'd5, 1, 6'd8, 1, 0, 32'h738, 32'h734);
        push(2'b11, 3'b000, 32'h740, 32'hC, 32'd9, 32'd9, 1, 6'd9, 1, 1, 32'h74C, 32'h744);
        push(2'b01, 3'b000, 32'h1000, 32'hFFFFF000, 32'd0, 32'd0, 1, 6'd15, 1, 1, 32'h0, 32'h1004);
        repeat (3) tick();

        // Fill with pending entries; wakeups must not let a younger entry bypass the head.
        push(2'b00, 3'b000, 32'h40, 32'h8, 32'd0, 32'd0, 0, 6'd10, 1, 1, 32'h48, 32'h44);
        push(2'b00, 3'b110, 32'h50, 32'h10, 32'd0, 32'd0, 0, 6'd11, 1, 1, 32'h60, 32'h54);
        push(2'b00, 3'b111, 32'h60, 32'h4, 32'd0, 32'd0, 0, 6'd12, 1, 0, 32'h64, 32'h64);
        push(2'b10, 3'b000, 32'h70, 32'h11, 32'd0, 32'd0, 0, 6'd13, 1, 1, 32'h110, 32'h74);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        wake(6'd12, 32'd1, 32'd2);
        repeat (2) tick();
        chk("no_bypass_valid", out_valid, 0);
        chk("no_bypass_count", count, 4);
        wake(6'd10, 32'd7, 32'd7);
        chk("full_pop_in_ready", in_ready, 0);
        in_valid = 1'b1; in_tag = 6'd40; in_ops_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("full_pop_count", count, 3);
        repeat (2) tick();
        chk("head_blocks_valid", out_valid, 0);
        chk("head_blocks_count", count, 3);
        wake(6'd11, 32'd1, 32'd2);
        repeat (3) tick();
        wake(6'd13, 32'h100, 32'd0);
        repeat (3) tick();
        chk("drained_count", count, 0);

        // Push captures a same-cycle wakeup even with ops invalid.
        wake_valid = 1'b1; wake_tag = 6'd20; wake_rs1 = 32'd9; wake_rs2 = 32'd9;
        push(2'b00, 3'b000, 32'h80, 32'h8, 32'd0, 32'd1, 0, 6'd20, 1, 1, 32'h88, 32'h84);
        wake_valid = 1'b0;
        repeat (2) tick();

        // Push and pop in the same cycle.
        push(2'b00, 3'b000, 32'h90, 32'h0, 32'd1, 32'd1, 1, 6'd21, 1, 1, 32'h90, 32'h94);
        push(2'b00, 3'b001, 32'hA0, 32'h4, 32'd1, 32'd1, 1, 6'd22, 1, 0, 32'hA4, 32'hA4);
        chk("push_pop_count", count, 1);
        repeat (3) tick();

        // JALR stalled by out_ready=0, then released.
        out_ready = 1'b0;
        push(2'b10, 3'b000, 32'h400, 32'h4, 32'h203, 32'd0, 1, 6'd30, 1, 1, 32'h206, 32'h404);
        repeat (4) tick();
        chk("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("release_valid", out_valid, 0);

        // Squash with queued entries, full output slot and a simultaneous push.
        out_ready = 1'b0;
        push(2'b01, 3'b000, 32'h500, 32'h100, 32'd0, 32'd0, 1, 6'd50, 1, 1, 32'h600, 32'h504);
        push(2'b00, 3'b000, 32'h510, 32'h4, 32'd0, 32'd0, 0, 6'd51, 0, 0, 32'h0, 32'h0);
        push(2'b00, 3'b000, 32'h520, 32'h4, 32'd0, 32'd0, 0, 6'd52, 0, 0, 32'h0, 32'h0);
        push(2'b00, 3'b000, 32'h530, 32'h4, 32'd0, 32'd0, 0, 6'd53, 0, 0, 32'h0, 32'h0);
        chk("pre_squash_count", count, 3);
        chk("pre_squash_valid", out_valid, 1);
        squash = 1'b1; in_valid = 1'b1; in_tag = 6'd54; in_ops_valid = 1'b1;
        tick();
        squash = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("squash_count", count, 0);
        chk("squash_valid", out_valid, 0);
        out_ready = 1'b1;
        wake(6'd51, 32'd0, 32'd0);
        repeat (3) tick();
        chk("squash_dropped", out_valid, 0);
        chk("squash_count_after", count, 0);

        // BNE with rs1==rs2 predicted taken, then reset mid-stream.
        out_ready = 1'b0;
`ifdef FU_BRANCH_PREDICT_EN
        in_pred_taken = 1'b1; in_pred_target = 32'h608;
`endif
        use_mis_g = 1'b1; e_mis_g = 1'b1;
        push(2'b00, 3'b001, 32'h600, 32'h8, 32'h33, 32'h33, 1, 6'd60, 1, 0, 32'h608, 32'h604);
        use_mis_g = 1'b0;
`ifdef FU_BRANCH_PREDICT_EN
        in_pred_taken = 1'b0; in_pred_target = 32'h0;
`endif
        push(2'b01, 3'b000, 32'h610, 32'h8, 32'd0, 32'd0, 1, 6'd61, 0, 0, 32'h0, 32'h0);
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_count", count, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_count", count, 0);
        chk("mid_reset_in_ready", in_ready, 1);
`ifdef FU_BRANCH_PREDICT_EN
        chk("mid_reset_mispredict", out_mispredict, 0);
`endif
        exp_q.delete();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("post_reset_valid", out_valid, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_branch_queue.md
FU_BRANCH_QUEUE -- requirements
Module: fu_branch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand, PC and target width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter TAG_W, default 6, giving the width of the operand wakeup and result tag.
REQ-004 clock  in  1  system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 squash  in  1  synchronous flush of all entries and the output register.
REQ-007 in_valid / in_ready  in / out  1 / 1  dispatch handshake.
REQ-008 in_kind  in  2  operation kind: 00 = conditional branch, 01 = JAL, 10 = JALR; 11 is illegal and treated as 00.
REQ-009 in_funct3  in  3  branch condition; in_pc and in_imm  in  XLEN each; in_imm is already sign-extended.
REQ-010 in_rs1, in_rs2  in  XLEN each; in_ops_valid  in  1; in_tag  in  TAG_W.
REQ-011 wake_valid  in  1; wake_tag  in  TAG_W; wake_rs1, wake_rs2  in  XLEN each; together they form the late-operand broadcast.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake; out_tag  out  TAG_W.
REQ-013 out_take  out  1; out_target  out  XLEN; out_link  out  XLEN, equal to PC+4.
REQ-014 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 The entries SHALL form an in-order circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-016 in_ready SHALL equal (count < DEPTH), and a push SHALL occur on in_valid && in_ready.
REQ-017 On wake_valid, every occupied entry whose tag equals wake_tag and whose operands are not yet valid SHALL capture wake_rs1/wake_rs2 and set its operands-valid bit.
REQ-018 A push whose in_tag matches an active wakeup in the same cycle SHALL capture the wake values, even when in_ops_valid=0.
REQ-019 Issue SHALL occur when count > 0, the head operands are valid, and (!out_valid || out_ready); on issue the head SHALL pop and the output register SHALL load.
REQ-020 Only the head entry SHALL ever issue; no entry may bypass an older one.
REQ-021 Latency SHALL be one cycle: a push with valid operands into an empty queue with a free output register at edge t SHALL give out_valid=1 after edge t+1.
REQ-022 A wakeup landing on the head at edge t SHALL make the head eligible to issue in the cycle that follows.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 When count=DEPTH, in_ready SHALL be 0 even if a pop occurs in that cycle.
REQ-025 Conditional branches SHALL be taken as follows: funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU; funct3 010 and 011 SHALL be not taken.
REQ-026 JAL and JALR SHALL always be taken.
REQ-027 out_target SHALL be pc+imm for a conditional branch or JAL, and (rs1+imm) with bit 0 cleared for JALR; all additions wrap modulo 2^XLEN.
REQ-028 out_link SHALL be pc+4 for every kind.
REQ-029 While out_valid && !out_ready, all out_* signals SHALL be held stable.
REQ-030 squash SHALL, at the next edge, empty the queue (count=0, pointers=0) and clear out_valid.
REQ-031 squash SHALL take priority over a same-cycle push, wakeup or issue.

Reset
REQ-032 Asserting reset SHALL immediately clear out_valid, count, the pointers and all entry valid bits, and SHALL set out_take, out_target, out_link and out_tag to 0.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Reset in the middle of an operation SHALL discard all queued and output state, with no partial result emitted.

Configuration
REQ-035 The feature macro SHALL be FU_BRANCH_PREDICT_EN.
REQ-036 When FU_BRANCH_PREDICT_EN is defined, the inputs in_pred_taken (1) and in_pred_target (XLEN) SHALL be stored per entry, and an output out_mispredict (1) SHALL be present.
REQ-037 With the macro defined, out_mispredict SHALL be (take != pred_taken) || (take && target != pred_target); it SHALL be registered alongside the other out_* signals and reset to 0.
REQ-038 When FU_BRANCH_PREDICT_EN is undefined, those ports and storage SHALL be absent.

Verification
REQ-039 Push BEQ with pc=0x100, imm=0x20, rs1=rs2=5, ops valid, out_ready=1 -> one cycle later out_valid=1, out_take=1, out_target=0x120, out_link=0x104.
REQ-040 Push BLT with rs1=0xFFFFFFFF, rs2=1 and BLTU with the same operands -> first result take=1, second take=0, in push order.
REQ-041 Push 4 entries, all with ops invalid -> count=4 and in_ready=0; wake the tag of entry 2 -> nothing issues; wake the head tag -> only the head issues, so entries issue strictly in order.
REQ-042 Push JALR with rs1=0x203, imm=0x4 and hold out_ready=0 for 3 cycles -> out_target=0x206, held stable, released on the out_ready cycle.
REQ-043 With 3 entries queued and out_valid=1, assert squash with a simultaneous push -> next cycle count=0, out_valid=0, and the pushed entry is dropped.
REQ-044 With the macro defined, push BNE with rs1=rs2, pred_taken=1 -> out_take=0, out_mispredict=1; assert reset mid-stream -> out_valid=0 and count=0 immediately.
